// File: rtl/xor_stream_ctrl.sv
// XOR stream controller: reads a byte buffer, XORs each byte with a key that
// rotates left once per byte, and writes the result back in place.
module xor_stream_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base_addr,
    input  logic [7:0] length,
    input  logic [7:0] key,
    input  logic [7:0] mem_rdata,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] base_r;
    logic [7:0] len_r;
    logic [7:0] key_r;
    logic [7:0] idx_r;
    logic [7:0] count_r;
    logic [7:0] data_r;
    logic [7:0] idx_next_s;
    logic       last_s;

    assign idx_next_s = idx_r + 8'd1;
    assign last_s     = (idx_next_s == len_r);
    assign count      = count_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort only matters while a transfer is in flight
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = (length == 8'd0) ? S_DONE : S_READ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    state_s = S_IDLE;
                end else if (last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_READ;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Job parameters, byte index, running key and data register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_r  <= 8'h00;
            len_r   <= 8'h00;
            key_r   <= 8'h00;
            idx_r   <= 8'h00;
            count_r <= 8'h00;
            data_r  <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        base_r  <= base_addr;
                        len_r   <= length;
                        key_r   <= key;
                        idx_r   <= 8'h00;
                        count_r <= 8'h00;
                        data_r  <= 8'h00;
                    end
                end
                S_READ: begin
                    if (!abort) begin
                        data_r <= mem_rdata ^ key_r;
                    end
                end
                S_WRITE: begin
                    if (!abort) begin
                        idx_r   <= idx_next_s;
                        count_r <= count_r + 8'd1;
                        key_r   <= {key_r[6:0], key_r[7]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes are combinational so abort can suppress them in-cycle
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            S_READ: begin
                busy     = 1'b1;
                mem_addr = base_r + idx_r;
                mem_read = ~abort;
            end
            S_WRITE: begin
                busy      = 1'b1;
                mem_addr  = base_r + idx_r;
                mem_wdata = data_r;
                mem_write = ~abort;
            end
            S_DONE:  done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
